bit_scatter20: RTL and testbench

Column-wise assembler that writes one bit per lane into 20 lanes of 16-bit words. It is the write-side counterpart of the 20-lane bit-select read path. Each accepted beat carries a 20-bit slice and a 4-bit column index; bit i of the slice is stored at column `in_sel` of lane word i. When a frame completes, all 20 words are presented at once behind a valid/ready handshake. The block sits between a serial bit-plane producer and any consumer of full 16-bit lane words.

---
 rtl/bit_scatter20.sv | 84 ++++++++
 tb/tb_bit_scatter20.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bit_scatter20.sv
// ---------------------------------------------------------------------------
// bit_scatter20 : writes one bit per lane into LANES words of WIDTH bits, column by column.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bit_scatter20 #(
    parameter int LANES = 20,
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_bits,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_words,
    output logic [WIDTH-1:0]         out_mask
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [LANES*WIDTH-1:0]   words_q, words_d;
    logic [WIDTH-1:0]         mask_q,  mask_d;
    logic                     w_accept;

    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        mask_d   = mask_q;
        in_ready = (state_q == S_FILL) && rst_n;
        w_accept = in_valid && in_ready;

        if (state_q == S_FILL) begin
            if (w_accept) begin
                // Out-of-range columns match no c, so the beat only counts for in_last.
                for (int c = 0; c < WIDTH; c++) begin
                    if (in_sel == SEL_W'(c)) begin
                        for (int l = 0; l < LANES; l++) begin
                            words_d[l*WIDTH + c] = in_bits[l];
                        end
                        mask_d[c] = 1'b1;
                    end
                end
                if (in_last || (&mask_d)) begin
                    state_d = S_HOLD;
                end
            end
        end else begin
            if (out_ready) begin
                words_d = '0;
                mask_d  = '0;
                state_d = S_FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            words_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            mask_q  <= mask_d;
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign out_words = words_q;
    assign out_mask  = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_scatter20.sv
// ---------------------------------------------------------------------------
// tb_bit_scatter20 : directed self-checking bench for bit_scatter20 (16- and 12-column builds).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bit_scatter20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_last, out_ready;
    logic [19:0]  in_bits;
    logic [3:0]   in_sel;
    logic         in_ready, out_valid;
    logic [319:0] out_words;
    logic [15:0]  out_mask;

    logic         b_in_valid, b_in_last, b_out_ready;
    logic [19:0]  b_in_bits;
    logic [3:0]   b_in_sel;
    logic         b_in_ready, b_out_valid;
    logic [239:0] b_out_words;
    logic [11:0]  b_out_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_scatter20 #(.LANES(20), .WIDTH(16), .SEL_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_words(out_words), .out_mask(out_mask)
    );

    bit_scatter20 #(.LANES(20), .WIDTH(12), .SEL_W(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bits(b_in_bits),
        .in_sel(b_in_sel), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_words(b_out_words), .out_mask(b_out_mask)
    );

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sel, input logic [19:0] bits, input logic last);
        in_valid = 1'b1;
        in_sel   = sel;
        in_bits  = bits;
        in_last  = last;
        chk("in_ready_beat", 320'(in_ready), 320'(1'b1));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_bits = '0; in_sel = '0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
        b_in_bits = '0; b_in_sel = '0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", 320'(in_ready), 320'(1'b0));
        chk("rst_out_valid", 320'(out_valid), 320'(1'b0));
        chk("rst_mask", 320'(out_mask), 320'(16'h0));
        chk("rst_words", out_words, 320'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 320'(in_ready), 320'(1'b1));

        // Full frame, alternating columns
        for (int c = 0; c < 16; c++) begin
            if (c == 15) chk("full_no_early_valid", 320'(out_valid), 320'(1'b0));
            send(4'(c), (c % 2 == 0) ? 20'hFFFFF : 20'h0, 1'b0);
        end
        chk("full_out_valid", 320'(out_valid), 320'(1'b1));
        chk("full_words", out_words, {20{16'h5555}});
        chk("full_mask", 320'(out_mask), 320'(16'hFFFF));
        chk("full_hold_in_ready", 320'(in_ready), 320'(1'b0));
        tick();
        chk("full_after_in_ready", 320'(in_ready), 320'(1'b1));
        chk("full_after_valid", 320'(out_valid), 320'(1'b0));
        chk("full_after_words", out_words, 320'h0);

        // Lane independence
        send(4'd3, 20'h00001, 1'b0);
        send(4'd15, 20'h80000, 1'b0);
        send(4'd0, 20'h00000, 1'b1);
        chk("lane_valid", 320'(out_valid), 320'(1'b1));
        chk("lane_words", out_words, {16'h8000, {18{16'h0000}}, 16'h0008});
        chk("lane_mask", 320'(out_mask), 320'(16'h8009));
        tick();

        // Backpressure
        out_ready = 1'b0;
        send(4'd1, 20'hFFFFF, 1'b1);
        in_valid = 1'b1; in_sel = 4'd2; in_bits = 20'hFFFFF; in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 320'(in_ready), 320'(1'b0));
            chk("bp_valid", 320'(out_valid), 320'(1'b1));
            chk("bp_words", out_words, {20{16'h0002}});
            chk("bp_mask", 320'(out_mask), 320'(16'h0002));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_handoff_valid", 320'(out_valid), 320'(1'b0));
        chk("bp_handoff_words", out_words, 320'h0);
        chk("bp_handoff_mask", 320'(out_mask), 320'(16'h0));
        in_valid = 1'b0;
        send(4'd4, 20'hFFFFF, 1'b1);
        chk("bp_next_words", out_words, {20{16'h0010}});
        chk("bp_next_mask", 320'(out_mask), 320'(16'h0010));
        tick();

        // Overwrite
        send(4'd7, 20'hFFFFF, 1'b0);
        chk("ow_first_words", out_words, {20{16'h0080}});
        send(4'd7, 20'h00000, 1'b1);
        chk("ow_valid", 320'(out_valid), 320'(1'b1));
        chk("ow_words", out_words, 320'h0);
        chk("ow_mask", 320'(out_mask), 320'(16'h0080));
        tick();

        // Out-of-range column on the 12-column build
        b_in_valid = 1'b1; b_in_sel = 4'd2; b_in_bits = 20'hFFFFF; b_in_last = 1'b0;
        chk("oor_ready", 320'(b_in_ready), 320'(1'b1));
        tick();
        b_in_sel = 4'd13; b_in_bits = 20'hFFFFF; b_in_last = 1'b1;
        chk("oor_ready2", 320'(b_in_ready), 320'(1'b1));
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("oor_valid", 320'(b_out_valid), 320'(1'b1));
        chk("oor_words", 320'(b_out_words), 320'({20{12'h004}}));
        chk("oor_mask", 320'(b_out_mask), 320'(12'h004));
        tick();

        // Reset mid-frame
        for (int c = 0; c < 5; c++) send(4'(c), 20'hFFFFF, 1'b0);
        chk("mid_mask_pre", 320'(out_mask), 320'(16'h001F));
        rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 4'd5; in_bits = 20'hFFFFF; in_last = 1'b1;
        #1;
        chk("mid_rst_in_ready", 320'(in_ready), 320'(1'b0));
        tick();
        chk("mid_mask", 320'(out_mask), 320'(16'h0));
        chk("mid_words", out_words, 320'h0);
        chk("mid_valid", 320'(out_valid), 320'(1'b0));
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("mid_after_in_ready", 320'(in_ready), 320'(1'b1));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_valid", 320'(out_valid), 320'(1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
